// File: rtl/ripple_acc_pkg.sv
// Shared types, default widths and helpers for the ripple accumulator.
package ripple_acc_pkg;

  // ACCUM: summing words of the current frame.
  // OUTPUT: presenting the finished frame sum on the output port.
  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } acc_state_e;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_ACC_WIDTH  = 8;
  localparam int DEF_CNT_WIDTH  = 4;

  // Increment that sticks at max_v instead of wrapping.
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ripple_adder_n.sv
// Parametrised ripple-carry adder: a chain of W full-adder cells, purely combinational.
module ripple_adder_n #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         co,
  output logic [W-1:0] s
);

  logic [W:0] c;

  assign c[0] = ci;

  // One full-adder cell per bit; carry ripples from bit 0 upward.
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign co = c[W];

endmodule

// File: rtl/ripple_accumulator.sv
// Frame accumulator: sums a framed stream of words with a ripple adder and
// emits sum, word count and sticky overflow per frame.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A producer holds data stable while valid is high and ready
// is low; valid does not depend on ready. Here din_rd may combinationally
// follow dout_rd (OUTPUT state) so that frames can run back to back.
module ripple_accumulator
  import ripple_acc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_last,
  input  logic                  din_vld,
  output logic                  din_rd,
  output logic [ACC_WIDTH-1:0]  dout_data,
  output logic [CNT_WIDTH-1:0]  dout_cnt,
  output logic                  dout_ovf,
  output logic                  dout_vld,
  input  logic                  dout_rd,
  output acc_state_e            dbg_state_o
);

  localparam int unsigned CNT_MAX = (CNT_WIDTH >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << CNT_WIDTH) - 32'd1);

  acc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0] add_a;
  logic [ACC_WIDTH-1:0] add_b;
  logic [ACC_WIDTH-1:0] add_s;
  logic                 add_co;

  // In OUTPUT any accepted word is the first of a new frame, so the adder
  // starts from zero instead of the finished sum.
  assign add_a = (state_q == OUTPUT) ? '0 : acc_q;
  assign add_b = ACC_WIDTH'(din_data);

  ripple_adder_n #(
    .W (ACC_WIDTH)
  ) u_adder (
    .a  (add_a),
    .b  (add_b),
    .ci (1'b0),
    .co (add_co),
    .s  (add_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: begin
        if (din_vld && din_last) state_d = OUTPUT;
      end
      OUTPUT: begin
        if (dout_rd) state_d = (din_vld && din_last) ? OUTPUT : ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // FSM outputs: handshake strobes decoded from state.
  always_comb begin
    din_rd   = 1'b1;
    dout_vld = 1'b0;
    case (state_q)
      ACCUM: begin
        din_rd   = 1'b1;
        dout_vld = 1'b0;
      end
      OUTPUT: begin
        din_rd   = dout_rd;
        dout_vld = 1'b1;
      end
      default: begin
        din_rd   = 1'b1;
        dout_vld = 1'b0;
      end
    endcase
  end

  // Datapath next values; registers only move on an accepted word or a drained output.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    case (state_q)
      ACCUM: begin
        if (din_vld) begin
          acc_d = add_s;
          ovf_d = ovf_q | add_co;
          cnt_d = CNT_WIDTH'(sat_inc(32'(cnt_q), CNT_MAX));
        end
      end
      OUTPUT: begin
        if (dout_rd) begin
          if (din_vld) begin
            acc_d = add_s;
            cnt_d = CNT_WIDTH'(1);
            ovf_d = 1'b0;
          end else begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
          end
        end
      end
      default: begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
      end
    endcase
  end

  // Datapath registers; a reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign dout_data   = acc_q;
  assign dout_cnt    = cnt_q;
  assign dout_ovf    = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ripple_accumulator.sv
// Directed bench for ripple_accumulator (DATA_WIDTH=4, ACC_WIDTH=8, CNT_WIDTH=4).
module tb_ripple_accumulator;
  import ripple_acc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] din_data;
  logic       din_last;
  logic       din_vld;
  logic       din_rd;
  logic [7:0] dout_data;
  logic [3:0] dout_cnt;
  logic       dout_ovf;
  logic       dout_vld;
  logic       dout_rd;
  acc_state_e dbg_state;

  int n_vec;
  int n_err;

  logic [7:0] exp_q[$];

  ripple_accumulator #(
    .DATA_WIDTH (4),
    .ACC_WIDTH  (8),
    .CNT_WIDTH  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din_data    (din_data),
    .din_last    (din_last),
    .din_vld     (din_vld),
    .din_rd      (din_rd),
    .dout_data   (dout_data),
    .dout_cnt    (dout_cnt),
    .dout_ovf    (dout_ovf),
    .dout_vld    (dout_vld),
    .dout_rd     (dout_rd),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [7:0] data,
                           input logic [3:0] cnt, input logic ovf);
    check_eq({tag, "_vld"},  32'(dout_vld),  32'(vld));
    check_eq({tag, "_data"}, 32'(dout_data), 32'(data));
    check_eq({tag, "_cnt"},  32'(dout_cnt),  32'(cnt));
    check_eq({tag, "_ovf"},  32'(dout_ovf),  32'(ovf));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [3:0] data, input logic last);
    din_vld  = vld;
    din_data = data;
    din_last = last;
  endtask

  // Scoreboard: every output handshake must deliver the next expected frame sum.
  always @(negedge clk) begin
    if (rst_n && dout_vld && dout_rd) begin
      if (exp_q.size() == 0) check_eq("sb_extra_output", 32'(dout_data), 32'hFFFF_FFFF);
      else                   check_eq("sb_sum", 32'(dout_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    dout_rd = 1'b1;
    drive(1'b0, 4'd0, 1'b0);
    exp_q = '{8'd15, 8'd44, 8'd9, 8'd2, 8'd3, 8'd4, 8'd1, 8'd5};

    // Reset state.
    step();
    step();
    check_out("reset", 1'b0, 8'd0, 4'd0, 1'b0);
    check_eq("reset_din_rd", 32'(din_rd), 32'd1);
    check_eq("reset_state", 32'(dbg_state), 32'(ACCUM));
    rst_n = 1'b1;
    step();

    // 1: frame 3,5,7 -> 15, then clears.
    drive(1'b1, 4'd3, 1'b0); step();
    drive(1'b1, 4'd5, 1'b0); step();
    drive(1'b1, 4'd7, 1'b1); step();
    drive(1'b0, 4'd0, 1'b0);
    check_out("t1_out", 1'b1, 8'd15, 4'd3, 1'b0);
    check_eq("t1_state", 32'(dbg_state), 32'(OUTPUT));
    step();
    check_out("t1_clr", 1'b0, 8'd0, 4'd0, 1'b0);

    // 2: 20 words of 15 -> 300 mod 256 = 44, overflow, count saturated at 15.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'd15, (i == 19));
      step();
    end
    drive(1'b0, 4'd0, 1'b0);
    check_out("t2_out", 1'b1, 8'd44, 4'd15, 1'b1);
    step();
    check_out("t2_clr", 1'b0, 8'd0, 4'd0, 1'b0);

    // 3: back-pressure holds the output, then a new word enters with no idle cycle.
    dout_rd = 1'b0;
    drive(1'b1, 4'd9, 1'b1); step();
    drive(1'b1, 4'd4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_hold_din_rd", 32'(din_rd), 32'd0);
      check_out("t3_hold", 1'b1, 8'd9, 4'd1, 1'b0);
      step();
    end
    dout_rd = 1'b1;
    drive(1'b1, 4'd2, 1'b1);
    #1;
    check_eq("t3_pass_din_rd", 32'(din_rd), 32'd1);
    step();
    drive(1'b0, 4'd0, 1'b0);
    check_out("t3_next", 1'b1, 8'd2, 4'd1, 1'b0);
    step();
    check_out("t3_clr", 1'b0, 8'd0, 4'd0, 1'b0);

    // 4: back-to-back frames {1,2},{4}.
    drive(1'b1, 4'd1, 1'b0); step();
    drive(1'b1, 4'd2, 1'b1); step();
    check_out("t4_f1", 1'b1, 8'd3, 4'd2, 1'b0);
    drive(1'b1, 4'd4, 1'b1);
    #1;
    check_eq("t4_din_rd", 32'(din_rd), 32'd1);
    step();
    drive(1'b0, 4'd0, 1'b0);
    check_out("t4_f2", 1'b1, 8'd4, 4'd1, 1'b0);
    step();
    check_out("t4_clr", 1'b0, 8'd0, 4'd0, 1'b0);

    // 5: asynchronous reset mid-frame discards the partial sum.
    drive(1'b1, 4'd6, 1'b0); step();
    drive(1'b1, 4'd6, 1'b0); step();
    drive(1'b0, 4'd0, 1'b0);
    check_out("t5_partial", 1'b0, 8'd12, 4'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("t5_async_rst", 1'b0, 8'd0, 4'd0, 1'b0);
    check_eq("t5_rst_din_rd", 32'(din_rd), 32'd1);
    step();
    rst_n = 1'b1;
    drive(1'b1, 4'd1, 1'b1); step();
    drive(1'b0, 4'd0, 1'b0);
    check_out("t5_after", 1'b1, 8'd1, 4'd1, 1'b0);
    step();

    // 6: bubbles inside a frame; junk data and last are ignored while din_vld=0.
    drive(1'b1, 4'd2, 1'b0); step();
    drive(1'b0, 4'bxxxx, 1'b0); step();
    drive(1'b0, 4'd15, 1'b1); step();
    check_out("t6_gap", 1'b0, 8'd2, 4'd1, 1'b0);
    drive(1'b1, 4'd3, 1'b1); step();
    drive(1'b0, 4'd0, 1'b0);
    check_out("t6_out", 1'b1, 8'd5, 4'd2, 1'b0);
    step();
    step();

    check_eq("sb_all_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
